// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types for the memory stall controller.
//   port_state_t : per-port request tracking state
//   port_sat     : "this port needs nothing more this cycle" predicate
package mem_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_BUSY = 2'd1,
    P_DONE = 2'd2
  } port_state_t;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 32;

  // A port is satisfied when it has no request, is answered this cycle,
  // or has already been answered earlier in the current stall.
  function automatic logic port_sat(input logic        req,
                                    input logic        resp,
                                    input port_state_t state);
    return !req || resp || (state == P_DONE);
  endfunction

endpackage

// File: rtl/mem_stall_ctrl_port_tracker.sv
// One memory port's request tracker (instanced for the I-port and D-port).
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   req_i            CPU-side request for this port
//   stall_i          global stall (combined across both ports)
//   mem_resp_i       memory done pulse
//   mem_rdata_i      memory read data
//   issue_o          gate for the memory-side request strobe(s)
//   sat_o            port satisfied this cycle
//   cpu_rdata_o      read data returned to the pipeline
module mem_port_tracker
  import mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            stall_i,
  input  logic            mem_resp_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            issue_o,
  output logic            sat_o,
  output logic [XLEN-1:0] cpu_rdata_o
);

  port_state_t     state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            accept;

  // rst_ni in the gate drops the memory request asynchronously on reset.
  assign issue_o = req_i && (state_q != P_DONE) && rst_ni;
  // Only a response to an outstanding request counts; stray pulses are ignored.
  assign accept  = issue_o && mem_resp_i;
  assign sat_o   = port_sat(req_i, mem_resp_i, state_q);

  assign cpu_rdata_o = (state_q == P_DONE) ? rdata_q : mem_rdata_i;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    if (!stall_i) begin
      state_d = P_IDLE;
    end else if (accept) begin
      state_d = P_DONE;
      rdata_d = mem_rdata_i;
    end else if (issue_o) begin
      state_d = P_BUSY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= P_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Pipeline-wide memory stall generator between the IF/MEM stages and the
// I/D memory ports. Stalls while either port has an unanswered request,
// holds early read data and suppresses re-issue until both ports finish.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cpu_imem_*  / cpu_dmem_*            pipeline-side requests and read data
//   mem_imem_*  / mem_dmem_*            memory-side requests, data, done pulses
//   stall_pipeline                      freeze pipeline registers and PC
//   stall_cnt, imem_stall_cnt,
//   dmem_stall_cnt                      saturating perf counters
// Configuration:
//   MEM_STALL_PERF_EN  defined   -> perf counters implemented
//                      undefined -> counters tied to zero
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             cpu_imem_read,
  input  logic [XLEN-1:0]  cpu_imem_addr,
  output logic [XLEN-1:0]  cpu_imem_rdata,

  input  logic             cpu_dmem_read,
  input  logic             cpu_dmem_write,
  input  logic [3:0]       cpu_dmem_mbe,
  input  logic [XLEN-1:0]  cpu_dmem_addr,
  input  logic [XLEN-1:0]  cpu_dmem_wdata,
  output logic [XLEN-1:0]  cpu_dmem_rdata,

  output logic             mem_imem_read,
  output logic [XLEN-1:0]  mem_imem_addr,
  input  logic [XLEN-1:0]  mem_imem_rdata,
  input  logic             mem_imem_resp,

  output logic             mem_dmem_read,
  output logic             mem_dmem_write,
  output logic [3:0]       mem_dmem_mbe,
  output logic [XLEN-1:0]  mem_dmem_addr,
  output logic [XLEN-1:0]  mem_dmem_wdata,
  input  logic [XLEN-1:0]  mem_dmem_rdata,
  input  logic             mem_dmem_resp,

  output logic             stall_pipeline,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] imem_stall_cnt,
  output logic [CNT_W-1:0] dmem_stall_cnt
);

  logic i_req, d_req;
  logic i_issue, d_issue;
  logic i_sat, d_sat;

  assign i_req = cpu_imem_read;
  assign d_req = cpu_dmem_read || cpu_dmem_write;

  assign stall_pipeline = !(i_sat && d_sat) && rst_n;

  mem_port_tracker #(.XLEN(XLEN)) u_imem (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (i_req),
    .stall_i     (stall_pipeline),
    .mem_resp_i  (mem_imem_resp),
    .mem_rdata_i (mem_imem_rdata),
    .issue_o     (i_issue),
    .sat_o       (i_sat),
    .cpu_rdata_o (cpu_imem_rdata)
  );

  mem_port_tracker #(.XLEN(XLEN)) u_dmem (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (d_req),
    .stall_i     (stall_pipeline),
    .mem_resp_i  (mem_dmem_resp),
    .mem_rdata_i (mem_dmem_rdata),
    .issue_o     (d_issue),
    .sat_o       (d_sat),
    .cpu_rdata_o (cpu_dmem_rdata)
  );

  assign mem_imem_read  = i_issue;
  assign mem_imem_addr  = cpu_imem_addr;

  assign mem_dmem_read  = cpu_dmem_read  && d_issue;
  assign mem_dmem_write = cpu_dmem_write && d_issue;
  assign mem_dmem_mbe   = cpu_dmem_mbe;
  assign mem_dmem_addr  = cpu_dmem_addr;
  assign mem_dmem_wdata = cpu_dmem_wdata;

`ifdef MEM_STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, imem_cnt_q, dmem_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, imem_cnt_d, dmem_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    imem_cnt_d  = imem_cnt_q;
    dmem_cnt_d  = dmem_cnt_q;
    if (stall_pipeline && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (!i_sat && (imem_cnt_q != '1))          imem_cnt_d  = imem_cnt_q + 1'b1;
    if (!d_sat && (dmem_cnt_q != '1))          dmem_cnt_d  = dmem_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      imem_cnt_q  <= '0;
      dmem_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      imem_cnt_q  <= imem_cnt_d;
      dmem_cnt_q  <= dmem_cnt_d;
    end
  end

  assign stall_cnt      = stall_cnt_q;
  assign imem_stall_cnt = imem_cnt_q;
  assign dmem_stall_cnt = dmem_cnt_q;
`else
  assign stall_cnt      = '0;
  assign imem_stall_cnt = '0;
  assign dmem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: table of per-cycle vectors with a
// scoreboard queue, plus hand-written reset and perf-counter sequences.
module tb_mem_stall_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cpu_imem_read;
  logic [XLEN-1:0]  cpu_imem_addr;
  logic [XLEN-1:0]  cpu_imem_rdata;
  logic             cpu_dmem_read;
  logic             cpu_dmem_write;
  logic [3:0]       cpu_dmem_mbe;
  logic [XLEN-1:0]  cpu_dmem_addr;
  logic [XLEN-1:0]  cpu_dmem_wdata;
  logic [XLEN-1:0]  cpu_dmem_rdata;
  logic             mem_imem_read;
  logic [XLEN-1:0]  mem_imem_addr;
  logic [XLEN-1:0]  mem_imem_rdata;
  logic             mem_imem_resp;
  logic             mem_dmem_read;
  logic             mem_dmem_write;
  logic [3:0]       mem_dmem_mbe;
  logic [XLEN-1:0]  mem_dmem_addr;
  logic [XLEN-1:0]  mem_dmem_wdata;
  logic [XLEN-1:0]  mem_dmem_rdata;
  logic             mem_dmem_resp;
  logic             stall_pipeline;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] imem_stall_cnt;
  logic [CNT_W-1:0] dmem_stall_cnt;

  mem_stall_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_imem_read  (cpu_imem_read),
    .cpu_imem_addr  (cpu_imem_addr),
    .cpu_imem_rdata (cpu_imem_rdata),
    .cpu_dmem_read  (cpu_dmem_read),
    .cpu_dmem_write (cpu_dmem_write),
    .cpu_dmem_mbe   (cpu_dmem_mbe),
    .cpu_dmem_addr  (cpu_dmem_addr),
    .cpu_dmem_wdata (cpu_dmem_wdata),
    .cpu_dmem_rdata (cpu_dmem_rdata),
    .mem_imem_read  (mem_imem_read),
    .mem_imem_addr  (mem_imem_addr),
    .mem_imem_rdata (mem_imem_rdata),
    .mem_imem_resp  (mem_imem_resp),
    .mem_dmem_read  (mem_dmem_read),
    .mem_dmem_write (mem_dmem_write),
    .mem_dmem_mbe   (mem_dmem_mbe),
    .mem_dmem_addr  (mem_dmem_addr),
    .mem_dmem_wdata (mem_dmem_wdata),
    .mem_dmem_rdata (mem_dmem_rdata),
    .mem_dmem_resp  (mem_dmem_resp),
    .stall_pipeline (stall_pipeline),
    .stall_cnt      (stall_cnt),
    .imem_stall_cnt (imem_stall_cnt),
    .dmem_stall_cnt (dmem_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, dw, irsp, drsp;
    logic [31:0] irdata, drdata;
    logic        e_stall, e_mir, e_mdr, e_mdw;
    logic [31:0] e_ird, e_drd;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic ir, dr, dw, irsp, drsp,
                              input logic [31:0] irdata, drdata,
                              input logic e_stall, e_mir, e_mdr, e_mdw,
                              input logic [31:0] e_ird, e_drd);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.irsp = irsp; v.drsp = drsp;
    v.irdata = irdata; v.drdata = drdata;
    v.e_stall = e_stall; v.e_mir = e_mir; v.e_mdr = e_mdr; v.e_mdw = e_mdw;
    v.e_ird = e_ird; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_imem_read  = v.ir;
    cpu_dmem_read  = v.dr;
    cpu_dmem_write = v.dw;
    mem_imem_resp  = v.irsp;
    mem_dmem_resp  = v.drsp;
    mem_imem_rdata = v.irdata;
    mem_dmem_rdata = v.drdata;
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk); #1;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, " stall"},      {31'b0, stall_pipeline}, {31'b0, e.e_stall});
    chk({tag, " mem_i_read"}, {31'b0, mem_imem_read},  {31'b0, e.e_mir});
    chk({tag, " mem_d_read"}, {31'b0, mem_dmem_read},  {31'b0, e.e_mdr});
    chk({tag, " mem_d_wr"},   {31'b0, mem_dmem_write}, {31'b0, e.e_mdw});
    chk({tag, " cpu_i_rd"},   cpu_imem_rdata,          e.e_ird);
    chk({tag, " cpu_d_rd"},   cpu_dmem_rdata,          e.e_drd);
  endtask

  task automatic chk_cnt(input string tag, input int s, input int i, input int d);
`ifdef MEM_STALL_PERF_EN
    chk({tag, " stall_cnt"}, 32'(stall_cnt),      32'(s));
    chk({tag, " imem_cnt"},  32'(imem_stall_cnt), 32'(i));
    chk({tag, " dmem_cnt"},  32'(dmem_stall_cnt), 32'(d));
`else
    chk({tag, " stall_cnt"}, 32'(stall_cnt),      32'(s - s));
    chk({tag, " imem_cnt"},  32'(imem_stall_cnt), 32'(i - i));
    chk({tag, " dmem_cnt"},  32'(dmem_stall_cnt), 32'(d - d));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, v;
    idle = mk(0,0,0,0,0, 32'h0,32'h0, 0,0,0,0, 32'h0,32'h0);

    // 1: both ports zero-wait
    vecs.push_back(mk(1,1,0,1,1, 32'hA1A1A1A1,32'hB1B1B1B1, 0,1,1,0, 32'hA1A1A1A1,32'hB1B1B1B1));
    vecs.push_back(idle);
    // 2: fetch answered in cycle 3
    vecs.push_back(mk(1,0,0,0,0, 32'hBAD00000,32'h0, 1,1,0,0, 32'hBAD00000,32'h0));
    vecs.push_back(mk(1,0,0,0,0, 32'hBAD00001,32'h0, 1,1,0,0, 32'hBAD00001,32'h0));
    vecs.push_back(mk(1,0,0,0,0, 32'hBAD00002,32'h0, 1,1,0,0, 32'hBAD00002,32'h0));
    vecs.push_back(mk(1,0,0,1,0, 32'h00000013,32'h0, 0,1,0,0, 32'h00000013,32'h0));
    vecs.push_back(idle);
    // 3: load early at cycle 1, fetch at cycle 4 (stray D resp at 3 ignored)
    vecs.push_back(mk(1,1,0,0,0, 32'h0,32'h0,        1,1,1,0, 32'h0,32'h0));
    vecs.push_back(mk(1,1,0,0,1, 32'h0,32'hDEADBEEF, 1,1,1,0, 32'h0,32'hDEADBEEF));
    vecs.push_back(mk(1,1,0,0,0, 32'h0,32'h11111111, 1,1,0,0, 32'h0,32'hDEADBEEF));
    vecs.push_back(mk(1,1,0,0,1, 32'h0,32'h22222222, 1,1,0,0, 32'h0,32'hDEADBEEF));
    vecs.push_back(mk(1,1,0,1,0, 32'h00000033,32'h33333333, 0,1,0,0, 32'h00000033,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,32'h44444444, 0,0,0,0, 32'h0,32'h44444444));
    // 4: store done at cycle 0, fetch at cycle 2
    vecs.push_back(mk(1,0,1,0,1, 32'h0,32'h0,  1,1,0,1, 32'h0,32'h0));
    vecs.push_back(mk(1,0,1,0,0, 32'h0,32'h0,  1,1,0,0, 32'h0,32'h0));
    vecs.push_back(mk(1,0,1,1,0, 32'h55,32'h0, 0,1,0,0, 32'h55,32'h0));
    vecs.push_back(idle);
    // D resp with no D request during a stall is ignored
    vecs.push_back(mk(1,0,0,0,1, 32'h0,32'h66666666,  1,1,0,0, 32'h0,32'h66666666));
    vecs.push_back(mk(1,1,0,0,0, 32'h0,32'h77777777,  1,1,1,0, 32'h0,32'h77777777));
    vecs.push_back(mk(1,1,0,1,1, 32'h88,32'h99999999, 0,1,1,0, 32'h88,32'h99999999));
    vecs.push_back(idle);

    rst_n = 1'b0;
    drive(idle);
    mem_imem_rdata = 32'h12345678;
    cpu_imem_addr  = 32'h00001000;
    cpu_dmem_addr  = 32'h00002004;
    cpu_dmem_wdata = 32'hCAFEF00D;
    cpu_dmem_mbe   = 4'b0110;
    cpu_imem_read  = 1'b1;
    #1;
    chk("rst stall",      {31'b0, stall_pipeline}, 32'h0);
    chk("rst mem_i_read", {31'b0, mem_imem_read},  32'h0);
    chk("rst cpu_i_rd",   cpu_imem_rdata,          32'h12345678);
    chk("pass i_addr",    mem_imem_addr,           32'h00001000);
    chk("pass d_addr",    mem_dmem_addr,           32'h00002004);
    chk("pass d_wdata",   mem_dmem_wdata,          32'hCAFEF00D);
    chk("pass d_mbe",     {28'b0, mem_dmem_mbe},   32'h6);
    chk_cnt("rst", 0, 0, 0);
    cpu_imem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

    // 5: reset while fetch pending aborts immediately, no replay after release
    v = mk(1,0,0,0,0, 32'h0,32'h0, 1,1,0,0, 32'h0,32'h0);
    apply(v, "r5c0");
    apply(v, "r5c1");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("r5 async stall",  {31'b0, stall_pipeline}, 32'h0);
    chk("r5 async i_read", {31'b0, mem_imem_read},  32'h0);
    @(posedge clk); #1;
    drive(idle);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r5 rel i_read", {31'b0, mem_imem_read},  32'h0);
    chk("r5 rel stall",  {31'b0, stall_pipeline}, 32'h0);
    apply(idle, "r5idle");
    chk_cnt("r5", 0, 0, 0);

    // 6: perf counters over scenario 2, then saturation on a long load
    for (int unsigned c = 0; c < 3; c++)
      apply(mk(1,0,0,0,0, 32'h0,32'h0, 1,1,0,0, 32'h0,32'h0), "p6");
    apply(mk(1,0,0,1,0, 32'h13,32'h0, 0,1,0,0, 32'h13,32'h0), "p6end");
    chk_cnt("p6", 3, 3, 0);
    for (int unsigned c = 0; c < 20; c++)
      apply(mk(0,1,0,0,0, 32'h0,32'h0, 1,0,1,0, 32'h0,32'h0), "sat");
    apply(mk(0,1,0,0,1, 32'h0,32'h5A5A5A5A, 0,0,1,0, 32'h0,32'h5A5A5A5A), "satend");
    chk_cnt("sat", 15, 3, 15);
    apply(idle, "final");

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
